// File: rtl/pe_row_sched_pkg.sv
// Shared types and widths for the PE row scheduler and its output buffer.
package pe_row_sched_pkg;

    localparam int WORD_W     = 24;
    localparam int PE_OUT_W   = 18;
    localparam int NUM_PE_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/pe_row_sched_psum_fifo2.sv
// Two-entry valid/ready buffer for row sums; writer guarantees space via credits.
module psum_fifo2 #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    logic         rd_fire;

    assign rd_fire  = rd_valid & rd_ready;
    assign rd_valid = (count != 2'd0);
    assign rd_data  = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (wr_en)
                wptr <= ~wptr;
            if (rd_fire)
                rptr <= ~rptr;
            case ({wr_en, rd_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/pe_row_sched.sv
// Row scheduler: loads PE weights, streams imap beats under a 2-credit limit,
// and sums the PE results into a 2-entry output buffer.
module pe_row_sched
    import pe_row_sched_pkg::*;
#(
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int PSUM_W = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [15:0]                  cfg_num_out,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  logic [WORD_W-1:0]            w_data,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [NUM_PE*WORD_W-1:0]     i_data,
    output logic [NUM_PE-1:0]            pe_w_en,
    output logic [WORD_W-1:0]            pe_w_data,
    output logic                         pe_ce,
    output logic [NUM_PE*WORD_W-1:0]     pe_in1,
    input  logic [NUM_PE*PE_OUT_W-1:0]   pe_out,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [PSUM_W-1:0]            o_data,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(NUM_PE - 1);

    function automatic logic [PSUM_W-1:0] row_sum(input logic [NUM_PE*PE_OUT_W-1:0] v);
        logic [PSUM_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < NUM_PE; k++)
            acc = acc + PSUM_W'(v[k*PE_OUT_W +: PE_OUT_W]);
        return acc;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  w_cnt;
    logic [15:0]       num_out_q;
    logic [15:0]       acc_cnt;
    logic              w_fire;
    logic              vld_p0;
    logic              vld_p1;
    logic [PSUM_W-1:0] sum_p1;
    logic [1:0]        fifo_cnt;
    logic [1:0]        credit_used;

    // Stage 0: handshakes and combinational drive of the PE row.
    assign w_fire      = w_ready & w_valid;
    assign credit_used = fifo_cnt + {1'b0, vld_p1};
    assign i_ready     = (state == COMPUTE) && (credit_used < 2'd2);
    assign vld_p0      = i_valid & i_ready;
    assign pe_ce       = vld_p0;
    assign pe_in1      = i_data;
    assign pe_w_data   = w_data;
    assign pe_w_en     = w_fire ? (NUM_PE'(1) << w_cnt) : '0;

    // Stage 1: PE results are valid one cycle after pe_ce; sum lands in the buffer.
    assign sum_p1 = row_sum(pe_out);

    psum_fifo2 #(
        .W (PSUM_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (vld_p1),
        .wr_data  (sum_p1),
        .rd_valid (o_valid),
        .rd_ready (o_ready),
        .rd_data  (o_data),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            w_cnt     <= '0;
            num_out_q <= '0;
            acc_cnt   <= '0;
            vld_p1    <= 1'b0;
            w_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= LOAD_W;
                        num_out_q <= cfg_num_out;
                        w_cnt     <= '0;
                        acc_cnt   <= '0;
                        w_ready   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (w_fire) begin
                        if (w_cnt == LAST_W) begin
                            w_ready <= 1'b0;
                            if (num_out_q == 16'd0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= COMPUTE;
                            end
                        end else begin
                            w_cnt <= w_cnt + CNT_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (vld_p0) begin
                        acc_cnt <= acc_cnt + 16'd1;
                        if (acc_cnt + 16'd1 == num_out_q)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // An empty buffer means no output handshake is outstanding.
                    if (!vld_p1 && fifo_cnt == 2'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_row_sched.sv
// Directed bench for pe_row_sched with a behavioural PE row stub.
module tb_pe_row_sched;

    localparam int NUM_PE = 3;
    localparam int PSUM_W = 20;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [15:0]           cfg_num_out;
    logic                  w_valid;
    logic                  w_ready;
    logic [23:0]           w_data;
    logic                  i_valid;
    logic                  i_ready;
    logic [NUM_PE*24-1:0]  i_data;
    logic [NUM_PE-1:0]     pe_w_en;
    logic [23:0]           pe_w_data;
    logic                  pe_ce;
    logic [NUM_PE*24-1:0]  pe_in1;
    logic [NUM_PE*18-1:0]  pe_out;
    logic                  o_valid;
    logic                  o_ready;
    logic [PSUM_W-1:0]     o_data;
    logic                  busy;
    logic                  done;

    int checks   = 0;
    int failures = 0;

    logic [23:0] wts [3];
    int          outs [8];
    int          exp_bp [5];

    always #5 clk = ~clk;

    pe_row_sched #(
        .NUM_PE (NUM_PE),
        .PSUM_W (PSUM_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_num_out (cfg_num_out),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_data      (w_data),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_data      (i_data),
        .pe_w_en     (pe_w_en),
        .pe_w_data   (pe_w_data),
        .pe_ce       (pe_ce),
        .pe_in1      (pe_in1),
        .pe_out      (pe_out),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .busy        (busy),
        .done        (done)
    );

    // PE stub: each PE returns the low 18 bits of its slice one cycle after pe_ce.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PE; k++)
            pe_out[k*18 +: 18] <= pe_ce ? pe_in1[k*24 +: 18] : 18'd0;
    end

    function automatic logic [71:0] mk(input int a, input int b, input int c);
        return {c[23:0], b[23:0], a[23:0]};
    endfunction

    function automatic logic [71:0] beat(input int n);
        return mk(100*n + 1, 100*n + 2, 100*n + 3);
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        step();
        start       = 1'b1;
        cfg_num_out = n[15:0];
    endtask

    task automatic load_weights();
        for (int k = 0; k < 3; k++) begin
            step();
            start   = 1'b0;
            w_valid = 1'b1;
            w_data  = wts[k];
            #1;
            chk("w_ready_load", w_ready, 1);
            chk("pe_w_en_load", pe_w_en, 72'(1) << k);
            chk("pe_w_data", pe_w_data, wts[k]);
            chk("pe_ce_load", pe_ce, 0);
            chk("i_ready_load", i_ready, 0);
        end
        step();
        w_valid = 1'b0;
        #1;
        chk("w_ready_after", w_ready, 0);
        chk("pe_w_en_after", pe_w_en, 0);
    endtask

    task automatic run_single(input int a, input int b, input int c, input int exp, input string tag);
        o_ready = 1'b1;
        do_start(1);
        load_weights();
        chk({tag, "_i_ready"}, i_ready, 1);
        i_valid = 1'b1;
        i_data  = mk(a, b, c);
        #1;
        chk({tag, "_pe_ce"}, pe_ce, 1);
        chk({tag, "_pe_in1"}, pe_in1, mk(a, b, c));
        step();
        i_valid = 1'b0;
        #1;
        chk({tag, "_o_valid_t1"}, o_valid, 0);
        chk({tag, "_i_ready_drain"}, i_ready, 0);
        step();
        chk({tag, "_o_valid_t2"}, o_valid, 1);
        chk({tag, "_o_data"}, o_data, exp);
        chk({tag, "_done_t2"}, done, 0);
        step();
        chk({tag, "_o_valid_t3"}, o_valid, 0);
        chk({tag, "_done_t3"}, done, 0);
        step();
        chk({tag, "_done_t4"}, done, 1);
        chk({tag, "_busy_t4"}, busy, 1);
        step();
        chk({tag, "_done_t5"}, done, 0);
        chk({tag, "_busy_t5"}, busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_o_valid"}, o_valid, 0);
        chk({tag, "_w_ready"}, w_ready, 0);
        chk({tag, "_i_ready"}, i_ready, 0);
        chk({tag, "_pe_ce"}, pe_ce, 0);
        chk({tag, "_pe_w_en"}, pe_w_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nout;
        bit done_seen;

        wts[0] = 24'h010203;
        wts[1] = 24'h040506;
        wts[2] = 24'h070809;
        exp_bp[0] = 6;
        exp_bp[1] = 306;
        exp_bp[2] = 606;
        exp_bp[3] = 906;
        exp_bp[4] = 1206;

        rst         = 1'b1;
        start       = 1'b0;
        cfg_num_out = 16'd0;
        w_valid     = 1'b0;
        w_data      = 24'd0;
        i_valid     = 1'b0;
        i_data      = '0;
        o_ready     = 1'b1;

        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Weight load followed by one pixel, 10+20+30.
        run_single(10, 20, 30, 60, "single");

        // All PE outputs at full scale.
        run_single(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 20'hBFFFD, "max");

        // Backpressure: five pixels with the output stalled, plus a stray start.
        o_ready = 1'b0;
        do_start(5);
        load_weights();
        acc  = 0;
        nout = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            i_valid     = (acc < 5);
            i_data      = beat(acc);
            start       = (cyc == 0);
            cfg_num_out = 16'd0;
            #1;
            if (i_valid && i_ready)
                acc++;
            step();
        end
        start   = 1'b0;
        i_valid = (acc < 5);
        i_data  = beat(acc);
        #1;
        chk("bp_accepts", acc, 2);
        chk("bp_i_ready", i_ready, 0);
        chk("bp_o_valid", o_valid, 1);
        chk("bp_o_data_held", o_data, 6);
        chk("bp_busy", busy, 1);

        o_ready   = 1'b1;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            i_valid = (acc < 5);
            i_data  = beat(acc);
            #1;
            if (o_valid && o_ready) begin
                if (nout < 8)
                    outs[nout] = int'(o_data);
                nout++;
            end
            if (i_valid && i_ready)
                acc++;
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            step();
        end
        i_valid = 1'b0;
        chk("bp_done_seen", done_seen, 1);
        chk("bp_total_accepts", acc, 5);
        chk("bp_num_outputs", nout, 5);
        for (int k = 0; k < 5; k++)
            chk("bp_out_value", outs[k], exp_bp[k]);
        step();
        chk("bp_busy_end", busy, 0);

        // Zero-length job: weights load, then done with the imap stream offered but never taken.
        o_ready = 1'b1;
        do_start(0);
        i_valid = 1'b1;
        i_data  = mk(5, 5, 5);
        load_weights();
        chk("zero_done", done, 1);
        chk("zero_i_ready", i_ready, 0);
        chk("zero_pe_ce", pe_ce, 0);
        step();
        i_valid = 1'b0;
        #1;
        chk("zero_done_clear", done, 0);
        chk("zero_busy", busy, 0);
        chk("zero_o_valid", o_valid, 0);

        // Reset in the middle of COMPUTE, then a clean job.
        do_start(3);
        load_weights();
        i_valid = 1'b1;
        i_data  = mk(1, 2, 3);
        step();
        rst     = 1'b1;
        i_valid = 1'b0;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        run_single(7, 8, 9, 24, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_row_sched.md
PE_ROW_SCHED -- requirements
Module: pe_row_sched

Interface
REQ-001 Parameters (name, default, meaning): NUM_PE, 3, PEs in the row; PSUM_W, 20, width of the row sum (18 + ceil(log2 NUM_PE)).
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
REQ-005 cfg_num_out  in  16  output pixels per job; sampled on an accepted start.
REQ-006 w_valid / w_ready / w_data  in / out / in  1/1/24  weight stream: three 8-bit taps per word, one word per PE, PE0 first.
REQ-007 i_valid / i_ready / i_data  in / out / in  1/1/NUM_PE*24  imap beat; slice k feeds PE k.
REQ-008 pe_w_en  out  NUM_PE  one-hot weight-load strobe, one bit per PE.
REQ-009 pe_w_data  out  24  weight word broadcast to all PEs.
REQ-010 pe_ce  out  1  compute enable, common to all PEs.
REQ-011 pe_in1  out  NUM_PE*24  imap slices to the PEs.
REQ-012 pe_out  in  NUM_PE*18  PE results; PE result is valid the cycle after pe_ce and is 0 otherwise.
REQ-013 o_valid / o_ready / o_data  out / in / out  1/1/PSUM_W  row-sum output stream.
REQ-014 busy / done  out / out  1/1  busy is high outside IDLE; done is a one-cycle pulse at job end.

Function
REQ-015 FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
REQ-016 IDLE -> LOAD_W on start; start in any other state is ignored.
REQ-017 LOAD_W: w_ready=1; beat n drives pe_w_en bit n and pe_w_data=w_data in the same cycle; after NUM_PE beats go to COMPUTE, or to DONE if cfg_num_out=0.
REQ-018 pe_ce is 0 in every state except COMPUTE; pe_w_en is 0 outside LOAD_W.
REQ-019 COMPUTE: an i beat is accepted when i_valid&i_ready; pe_ce=1 and pe_in1=i_data in that cycle, combinationally.
REQ-020 Beat accepted at cycle t: capture pe_out at t+1; register the zero-extended sum of all NUM_PE fields into a 2-entry output FIFO at t+2; o_valid may assert at t+2 (latency 2).
REQ-021 Arithmetic: sum is unsigned and exact in PSUM_W bits, with no truncation.
REQ-022 Credit rule: i_ready = (state==COMPUTE) & (fifo_occupancy + inflight < 2), where inflight is the number of beats accepted but not yet written into the FIFO; no result may ever be dropped.
REQ-023 The accepted-beat counter reaching cfg_num_out moves COMPUTE -> DRAIN; i_ready is then 0.
REQ-024 DRAIN -> DONE when inflight=0, the FIFO is empty and there is no o handshake pending.
REQ-025 DONE lasts one cycle with done=1, then IDLE.
REQ-026 A simultaneous FIFO write and read in the same cycle keeps occupancy unchanged; o_data is stable while o_valid&!o_ready.

Reset
REQ-027 On rst: state=IDLE; all counters, the FIFO and inflight clear; o_valid=0, busy=0, done=0, pe_ce=0, pe_w_en=0, w_ready=0, i_ready=0.
REQ-028 Reset mid-job abandons the job; PE weights are not reset, so every job reloads weights in LOAD_W.

Structure
REQ-029 Shared package holds the FSM state enum, the 24-bit word width, the 18-bit PE-out width and the NUM_PE default.
REQ-030 One sub-module, psum_fifo2 (2-entry valid/ready FIFO), holds the output buffer; the adder and FSM stay in pe_row_sched.

Verification
REQ-031 Weight load: start, 3 weight words 0x010203/0x040506/0x070809 -> pe_w_en = 001, 010, 100 on successive beats; pe_ce=0 throughout.
REQ-032 Single pixel: cfg_num_out=1, PE model outputs 10, 20, 30 -> o_data=60 exactly 2 cycles after the accept; done follows the o handshake.
REQ-033 Backpressure: cfg_num_out=5, o_ready=0 -> i_ready drops after 2 accepts; releasing o_ready yields all 5 sums in order with none lost.
REQ-034 Max values: all PE outputs 0x3FFFF -> o_data=0xBFFFD (no overflow at PSUM_W=20).
REQ-035 Boundaries: cfg_num_out=0 -> weights load then done with no i accept; start while busy is ignored.
REQ-036 Mid-COMPUTE rst -> next cycle all outputs at reset values; a new job completes normally.
